// File: rtl/perm_data_pipe_if.sv
// Stream bundle for the butterfly permutation pipe: upstream t_* beat with per-lane
// select bits, downstream i_* beat, plus flush and occupancy sideband.
interface perm_data_pipe_if #(
  parameter int LANES = 16,
  parameter int DW    = 32
);
  localparam int D  = $clog2(LANES);
  localparam int OW = $clog2(D + 1);

  logic [LANES*DW-1:0] t_data_dat;
  logic [LANES*D-1:0]  t_addr_dat;
  logic                t_valid;
  logic                t_ready;
  logic [LANES*DW-1:0] i_data_dat;
  logic                i_valid;
  logic                i_ready;
  logic                flush;
  logic [OW-1:0]       occupancy;

  modport master (
    output t_data_dat, t_addr_dat, t_valid, i_ready, flush,
    input  t_ready, i_data_dat, i_valid, occupancy
  );

  modport slave (
    input  t_data_dat, t_addr_dat, t_valid, i_ready, flush,
    output t_ready, i_data_dat, i_valid, occupancy
  );
endinterface

// File: rtl/perm_data_pipe.sv
// D-stage butterfly exchange pipeline: stage s swaps or broadcasts across lane distance
// LANES>>(s+1); select bits ride along with their beat, with a skid-free ready chain.
module perm_data_pipe #(
  parameter int LANES = 16,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  perm_data_pipe_if.slave bus
);
  localparam int D  = $clog2(LANES);
  localparam int OW = $clog2(D + 1);
  localparam int XW = LANES * DW;
  localparam int AW = LANES * D;

  logic [XW-1:0] data_p   [D];
  logic [AW-1:0] addr_p   [D];
  logic [D-1:0]  vld_p;
  logic [XW-1:0] stage_in [D];
  logic [AW-1:0] addr_in  [D];
  logic [D-1:0]  vld_in;
  logic [D-1:0]  rdy;
  logic          chain;
  logic          accept;
  logic [OW-1:0] occ;

  // Lane k takes its partner k ^ 2^(D-1-s) when its own select bit for stage s is set.
  function automatic logic [XW-1:0] exchange(input logic [XW-1:0] din,
                                             input logic [AW-1:0] sel,
                                             input int            s);
    logic [XW-1:0] r;
    int            p;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      p = k ^ (1 << (D - 1 - s));
      r[k*DW +: DW] = sel[k*D + s] ? din[p*DW +: DW] : din[k*DW +: DW];
    end
    return r;
  endfunction

  // A stage can move when it is empty or anything downstream of it can drain.
  always_comb begin
    chain = bus.i_ready;
    rdy   = '0;
    for (int s = D - 1; s >= 0; s--) begin
      chain  = chain | !vld_p[s];
      rdy[s] = chain;
    end
  end

  assign bus.t_ready = rdy[0] & !bus.flush;
  assign accept      = bus.t_valid & bus.t_ready;

  for (genvar s = 0; s < D; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign stage_in[s] = bus.t_data_dat;
      assign addr_in[s]  = bus.t_addr_dat;
      assign vld_in[s]   = accept;
    end else begin : g_next
      assign stage_in[s] = data_p[s-1];
      assign addr_in[s]  = addr_p[s-1];
      assign vld_in[s]   = vld_p[s-1];
    end
  end

  // ---- stage registers p0 .. p(D-1) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
      for (int s = 0; s < D; s++) begin
        data_p[s] <= '0;
        addr_p[s] <= '0;
      end
    end else begin
      for (int s = 0; s < D; s++) begin
        if (rdy[s]) begin
          data_p[s] <= exchange(stage_in[s], addr_in[s], s);
          addr_p[s] <= addr_in[s];
          vld_p[s]  <= vld_in[s];
        end
      end
      if (bus.flush) vld_p <= '0;
    end
  end

  always_comb begin
    occ = '0;
    for (int s = 0; s < D; s++) occ = occ + OW'(vld_p[s]);
  end

  assign bus.occupancy  = occ;
  assign bus.i_valid    = vld_p[D-1];
  assign bus.i_data_dat = data_p[D-1];
endmodule

// File: tb/tb_perm_data_pipe.sv
// Randomised and directed bench for perm_data_pipe at three lane/width configurations,
// scored against a lane-permutation model and a queue of in-flight beats.
module tb_perm_data_pipe;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  perm_data_pipe_if #(.LANES(16), .DW(32)) b16 ();
  perm_data_pipe_if #(.LANES(4),  .DW(8))  b4  ();
  perm_data_pipe_if #(.LANES(64), .DW(16)) b64 ();

  perm_data_pipe #(.LANES(16), .DW(32)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));
  perm_data_pipe #(.LANES(4),  .DW(8))  u4  (.clk(clk), .reset_n(reset_n), .bus(b4));
  perm_data_pipe #(.LANES(64), .DW(16)) u64 (.clk(clk), .reset_n(reset_n), .bus(b64));

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_out    = 0;
  logic [511:0] sb_q[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply each stage's rule to a lane array: lane k reads lane k^2^(d-1-s) when selected.
  function automatic logic [1023:0] perm_model(input logic [1023:0] din, input logic [383:0] adr,
                                               input int lanes, input int dw, input int d);
    logic [1023:0] cur;
    logic [1023:0] nxt;
    int            src;
    cur = din;
    for (int s = 0; s < d; s++) begin
      nxt = '0;
      for (int k = 0; k < lanes; k++) begin
        src = adr[k*d + s] ? (k ^ (1 << (d - 1 - s))) : k;
        for (int b = 0; b < dw; b++) nxt[k*dw + b] = cur[src*dw + b];
      end
      cur = nxt;
    end
    return cur;
  endfunction

  // Lane k holds the value k ^ m.
  function automatic logic [1023:0] ramp(input int lanes, input int dw, input int m);
    logic [1023:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++)
      for (int b = 0; b < dw; b++) r[k*dw + b] = 1'(((k ^ m) >> b) & 1);
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock of the 16-lane scoreboard: sample mid-cycle, then advance past the edge.
  task automatic cyc();
    logic          in_x, out_x, fl;
    logic [1023:0] m;
    logic [511:0]  exp;
    #2;
    in_x  = b16.t_valid && b16.t_ready;
    out_x = b16.i_valid && b16.i_ready;
    fl    = b16.flush;
    check("occupancy", 512'(b16.occupancy), 512'(sb_q.size()));
    check("t_ready", 512'(b16.t_ready), 512'(!fl && ((sb_q.size() < 4) || b16.i_ready)));
    if (out_x) begin
      n_out++;
      if (sb_q.size() == 0) check("unexpected_out", 512'(b16.i_valid), 512'(0));
      else begin
        exp = sb_q.pop_front();
        check("sb_data", b16.i_data_dat, exp);
      end
    end
    if (in_x) begin
      m = perm_model(1024'(b16.t_data_dat), 384'(b16.t_addr_dat), 16, 32, 4);
      sb_q.push_back(m[511:0]);
    end
    if (fl) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Send one beat with i_ready high and check the single-cycle i_valid pulse D cycles later.
  task automatic send16(input string tag, input logic [511:0] d, input logic [63:0] a,
                        input logic [511:0] exp);
    b16.t_data_dat = d;
    b16.t_addr_dat = a;
    b16.t_valid    = 1'b1;
    b16.i_ready    = 1'b1;
    #1;
    check({tag, "_tready"}, 512'(b16.t_ready), 512'(1));
    cyc();
    b16.t_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check({tag, "_ivalid"}, 512'(b16.i_valid), 512'(c == 4));
      if (c == 4) check({tag, "_data"}, b16.i_data_dat, exp);
      cyc();
    end
  endtask

  initial begin
    logic [511:0]  beats [6];
    logic [511:0]  e;
    logic [1023:0] w;
    int            idx, out0;
    logic          acc;

    b16.t_data_dat = '0; b16.t_addr_dat = '0; b16.t_valid = 0; b16.i_ready = 0; b16.flush = 0;
    b4.t_data_dat  = '0; b4.t_addr_dat  = '0; b4.t_valid  = 0; b4.i_ready  = 0; b4.flush  = 0;
    b64.t_data_dat = '0; b64.t_addr_dat = '0; b64.t_valid = 0; b64.i_ready = 0; b64.flush = 0;

    #12;
    check("rst_ivalid", 512'(b16.i_valid), 512'(0));
    check("rst_occ",    512'(b16.occupancy), 512'(0));
    check("rst_data",   b16.i_data_dat, 512'(0));
    #1 reset_n = 1'b1;
    #1;
    check("post_rst_tready", 512'(b16.t_ready), 512'(1));
    @(posedge clk);
    #1;

    // identity, full reversal, and single-lane broadcast
    w = ramp(16, 32, 0);
    send16("ident", w[511:0], 64'h0, w[511:0]);
    w = ramp(16, 32, 15);
    e = w[511:0];
    w = ramp(16, 32, 0);
    send16("allones", w[511:0], {64{1'b1}}, e);
    e = w[511:0];
    e[31:0] = 32'd1;
    send16("bcast", w[511:0], 64'h8, e);

    // full stall then release
    for (int i = 0; i < 6; i++) beats[i] = rand512();
    b16.i_ready = 1'b0;
    idx = 0;
    out0 = n_out;
    for (int c = 0; c < 8; c++) begin
      b16.t_valid    = (idx < 6);
      b16.t_data_dat = beats[idx < 6 ? idx : 5];
      b16.t_addr_dat = {$urandom, $urandom};
      #1;
      acc = b16.t_valid && b16.t_ready;
      cyc();
      if (acc) idx++;
    end
    check("stall_accepted", 512'(idx), 512'(4));
    check("stall_occ",      512'(b16.occupancy), 512'(4));
    check("stall_tready",   512'(b16.t_ready), 512'(0));
    b16.i_ready = 1'b1;
    #1;
    check("release_tready", 512'(b16.t_ready), 512'(1));
    for (int c = 0; c < 20; c++) begin
      b16.t_valid    = (idx < 6);
      b16.t_data_dat = beats[idx < 6 ? idx : 5];
      #1;
      acc = b16.t_valid && b16.t_ready;
      cyc();
      if (acc) idx++;
    end
    check("stall_out_count", 512'(n_out - out0), 512'(6));
    check("stall_sb_empty",  512'(sb_q.size()), 512'(0));

    // flush with three beats in flight and a competing input beat
    for (int i = 0; i < 3; i++) begin
      b16.t_valid = 1'b1;
      b16.t_data_dat = rand512();
      b16.t_addr_dat = {$urandom, $urandom};
      cyc();
    end
    b16.t_valid = 1'b0;
    check("preflush_occ", 512'(b16.occupancy), 512'(3));
    b16.flush = 1'b1;
    b16.t_valid = 1'b1;
    #1;
    check("flush_tready", 512'(b16.t_ready), 512'(0));
    cyc();
    b16.flush = 1'b0;
    b16.t_valid = 1'b0;
    check("flush_occ", 512'(b16.occupancy), 512'(0));
    out0 = n_out;
    for (int c = 0; c < 6; c++) begin
      check("flush_no_ivalid", 512'(b16.i_valid), 512'(0));
      cyc();
    end
    check("flush_no_out", 512'(n_out - out0), 512'(0));
    w = ramp(16, 32, 0);
    send16("postflush", w[511:0], 64'h0, w[511:0]);

    // reset asserted with two beats in flight, one at the output
    for (int i = 0; i < 2; i++) begin
      b16.t_valid = 1'b1;
      b16.t_data_dat = rand512() | 512'd1;
      b16.t_addr_dat = 64'h0;
      cyc();
    end
    b16.t_valid = 1'b0;
    cyc();
    b16.i_ready = 1'b0;
    cyc();
    check("prerst_ivalid", 512'(b16.i_valid), 512'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ivalid", 512'(b16.i_valid), 512'(0));
    check("midrst_data",   b16.i_data_dat, 512'(0));
    check("midrst_occ",    512'(b16.occupancy), 512'(0));
    sb_q.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check("rerst_tready", 512'(b16.t_ready), 512'(1));
    check("rerst_occ",    512'(b16.occupancy), 512'(0));
    w = ramp(16, 32, 0);
    send16("postrst", w[511:0], 64'h0, w[511:0]);

    // randomised traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      b16.t_valid    = ($urandom_range(0, 3) != 0);
      b16.i_ready    = ($urandom_range(0, 2) != 0);
      b16.flush      = ($urandom_range(0, 39) == 0);
      b16.t_data_dat = rand512();
      b16.t_addr_dat = {$urandom, $urandom};
      cyc();
    end
    b16.t_valid = 1'b0;
    b16.flush   = 1'b0;
    b16.i_ready = 1'b1;
    for (int c = 0; c < 12; c++) cyc();
    check("rand_drained", 512'(sb_q.size()), 512'(0));

    // LANES=4, DW=8: identity then reversal back to back
    w = ramp(4, 8, 0);
    b4.t_data_dat = w[31:0];
    b4.t_addr_dat = 8'h00;
    b4.t_valid = 1'b1;
    b4.i_ready = 1'b1;
    cyc();
    check("b4_early_ivalid", 512'(b4.i_valid), 512'(0));
    b4.t_addr_dat = 8'hFF;
    cyc();
    b4.t_valid = 1'b0;
    check("b4_id_ivalid", 512'(b4.i_valid), 512'(1));
    check("b4_id_data", 512'(b4.i_data_dat), 512'(w[31:0]));
    cyc();
    w = ramp(4, 8, 3);
    check("b4_rev_ivalid", 512'(b4.i_valid), 512'(1));
    check("b4_rev_data", 512'(b4.i_data_dat), 512'(w[31:0]));
    cyc();
    check("b4_idle_ivalid", 512'(b4.i_valid), 512'(0));

    // LANES=64, DW=16: identity then reversal back to back
    w = ramp(64, 16, 0);
    b64.t_data_dat = w;
    b64.t_addr_dat = '0;
    b64.t_valid = 1'b1;
    b64.i_ready = 1'b1;
    cyc();
    b64.t_addr_dat = {384{1'b1}};
    cyc();
    b64.t_valid = 1'b0;
    repeat (3) cyc();
    check("b64_early_ivalid", 512'(b64.i_valid), 512'(0));
    cyc();
    check("b64_id_ivalid", 512'(b64.i_valid), 512'(1));
    check("b64_id_lo", b64.i_data_dat[511:0], w[511:0]);
    check("b64_id_hi", b64.i_data_dat[1023:512], w[1023:512]);
    cyc();
    w = ramp(64, 16, 63);
    check("b64_rev_ivalid", 512'(b64.i_valid), 512'(1));
    check("b64_rev_lo", b64.i_data_dat[511:0], w[511:0]);
    check("b64_rev_hi", b64.i_data_dat[1023:512], w[1023:512]);
    cyc();
    check("b64_idle_ivalid", 512'(b64.i_valid), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/perm_data_pipe.md
PERM_DATA_PIPE -- requirements
Module: perm_data_pipe

Parameters
REQ-001 The block SHALL have parameter LANES, default 16, giving the lane count; a power of two, 2..64.
REQ-002 The block SHALL have parameter DW, default 32, giving the bits per lane.
REQ-003 The block SHALL derive localparam D = log2(LANES), the number of exchange stages (4 at defaults).

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port t_data_dat, input, LANES*DW bits: input lane k in bits [k*DW +: DW].
REQ-007 The block SHALL have port t_addr_dat, input, LANES*D bits: select bit for lane k at stage s in bit [k*D + s].
REQ-008 The block SHALL have port t_valid, input, 1 bit: the input beat is valid.
REQ-009 The block SHALL have port t_ready, output, 1 bit: the block accepts the input beat.
REQ-010 The block SHALL have port i_data_dat, output, LANES*DW bits: permuted result, lane k in bits [k*DW +: DW].
REQ-011 The block SHALL have port i_valid, output, 1 bit: the output beat is valid.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream accepts the output beat.
REQ-013 The block SHALL have port flush, input, 1 bit: synchronous discard of all in-flight beats.
REQ-014 The block SHALL have port occupancy, output, $clog2(D+1) bits: number of valid stage registers.

Function
REQ-015 A transfer SHALL occur on a port when valid and ready are both high at a rising clk edge.
REQ-016 The block SHALL contain D pipeline stages; stage s (0..D-1) holds a data register, an address register and a valid bit v[s].
REQ-017 Stage s SHALL use partner lane p = k XOR 2^(D-1-s), so the stages exchange across distance LANES/2 first and distance 1 last.
REQ-018 Stage s SHALL compute lane k as: sel = addr[k*D+s]; out[k] = sel ? in[p] : in[k].
REQ-019 Stage computation SHALL permit duplication: both partners selecting produces a swap; only one partner selecting produces a broadcast of one value into both lanes.
REQ-020 Address bits SHALL travel with their beat through every stage; a beat SHALL never use another beat's address.
REQ-021 Stage readiness SHALL be rdy[D-1] = !v[D-1] | i_ready and rdy[s] = !v[s] | rdy[s+1]; t_ready SHALL equal rdy[0].
REQ-022 When rdy[s] is high, stage s SHALL load the result of stage s-1, or the accepted input beat for s = 0, and v[s] SHALL take the upstream valid.
REQ-023 When rdy[s] is low, stage s SHALL hold its data, address and valid.
REQ-024 i_valid SHALL equal v[D-1], and i_data_dat SHALL equal the stage D-1 data register.
REQ-025 Latency SHALL be exactly D cycles from an input transfer to i_valid, with i_ready held high.
REQ-026 Throughput SHALL be one beat per cycle with no bubbles while i_ready stays high.
REQ-027 Under a full stall (i_ready low), the pipeline SHALL fill to D beats, occupancy SHALL reach D, and t_ready SHALL then drop.
REQ-028 When i_ready rises with the pipeline full, t_ready SHALL rise in the same cycle (combinational path), with no beat lost or duplicated.
REQ-029 occupancy SHALL equal the popcount of v[0..D-1], updated at every edge.
REQ-030 When flush is high at an edge, all v[s] SHALL clear; the input beat in that cycle SHALL be discarded; t_ready SHALL be forced low during flush.
REQ-031 flush SHALL take priority over i_ready and t_valid arriving in the same cycle; occupancy SHALL be 0 on the next cycle.
REQ-032 Data registers SHALL carry no reset requirement beyond REQ-033; the outputs SHALL depend only on valid stages.

Reset
REQ-033 While reset_n is low, asynchronously: all v[s] = 0, i_valid = 0, occupancy = 0, and data and address registers = 0, so i_data_dat = 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after reset_n rises SHALL emerge D cycles later.
REQ-035 t_ready SHALL be 1 on the first cycle after reset_n is released, provided flush is low.

Verification (LANES=16, DW=32)
REQ-036 The bench SHALL cover: lane k = k, addr all zeros, i_ready=1 -> identity output after exactly 4 cycles, i_valid pulsed for one cycle.
REQ-037 The bench SHALL cover: lane k = k, addr all ones -> output lane k = k XOR 15 (lane 0 = 15, lane 15 = 0).
REQ-038 The bench SHALL cover: lane k = k, only lane 0 stage 3 selecting (bit 3 = 1) -> lanes 0 and 1 both = 1; other lanes unchanged.
REQ-039 The bench SHALL cover: i_ready=0 with 6 beats offered -> 4 accepted, occupancy = 4, t_ready = 0; then i_ready=1 -> 6 beats out in order, none lost.
REQ-040 The bench SHALL cover: 3 beats in flight, flush pulsed for one cycle -> occupancy = 0 next cycle, no i_valid for those beats; a new beat emerges 4 cycles after acceptance.
REQ-041 The bench SHALL cover: reset_n dropped with 2 beats in flight -> i_valid = 0 immediately and i_data_dat = 0; after release, the pipeline behaves as empty.
REQ-042 The bench SHALL also repeat REQ-036 and REQ-037 at LANES=4, DW=8 and at LANES=64, DW=16.
